// File: rtl/upd1771c_sound_if.sv
// Host-side bus of the uPD1771C: port A data plus the port B nCS/nWR/DSB lines.
// The host drives the inputs through "master"; the sound block uses "slave".
interface upd1771c_sound_if;
  logic [7:0] PA_I;
  logic [7:0] PA_O;
  logic [7:0] PA_OE;
  logic [7:0] PB_I;
  logic [7:0] PB_O;
  logic [7:0] PB_OE;

  modport master (output PA_I, PB_I, input PA_O, PA_OE, PB_O, PB_OE);
  modport slave  (input PA_I, PB_I, output PA_O, PA_OE, PB_O, PB_OE);
endinterface

// File: rtl/upd1771c_sound.sv
// uPD1771C host packet interface (DSB handshake) driving a square-wave tone voice.
// Optional macro UPD1771C_TIMEOUT_EN aborts a stalled packet after TIMEOUT strobes.
module upd1771c_sound #(
  parameter int DIV_STEP = 8,
  parameter int PROC_DLY = 8,
  parameter int TIMEOUT  = 256
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            CKEN,
  input  logic            CH1,
  input  logic            CH2,
  upd1771c_sound_if.slave bus,
  output logic [7:0]      AOUT
);

  localparam int CW = 16;
  localparam int TW = 9 + $clog2(DIV_STEP + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_WAIT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      phase;
  logic            phi2p;
  logic            wr_now, wr_prev, wr_edge;
  logic            latch_byte, exec_pkt;
  logic [CW-1:0]   step_cnt;
  logic [7:0]      cmd_q;
  logic [1:0]      idx_q, last_idx;
  logic            flag_en_q;
  logic [7:0]      per_q;
  logic [4:0]      vol_q;
  logic            enabled, level;
  logic [7:0]      period;
  logic [4:0]      volume;
  logic [TW-1:0]   tone_cnt, half_len;

  assign phi2p   = CKEN && (phase == 2'd1);
  assign wr_now  = ~bus.PB_I[7] & ~bus.PB_I[6];
  assign wr_edge = phi2p & wr_now & ~wr_prev;
  assign last_idx = (cmd_q == 8'h02) ? 2'd3 : 2'd0;

  always_ff @(posedge CLK) begin
    if (RES) begin
      phase   <= 2'd0;
      wr_prev <= 1'b0;
    end else begin
      if (CKEN) phase <= phase + 2'd1;
      if (phi2p) wr_prev <= wr_now;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Writes landing in BUSY are dropped; a packet executes when its last byte's delay ends.
  always_comb begin
    state_d    = state_q;
    latch_byte = 1'b0;
    exec_pkt   = 1'b0;
    if (phi2p) begin
      case (state_q)
        ST_IDLE: begin
          if (wr_edge) begin
            state_d    = ST_BUSY;
            latch_byte = 1'b1;
          end
        end
        ST_BUSY: begin
          if (step_cnt == CW'(PROC_DLY - 1)) begin
            if (idx_q < last_idx) begin
              state_d = ST_WAIT;
            end else begin
              state_d  = ST_IDLE;
              exec_pkt = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wr_edge) begin
            state_d    = ST_BUSY;
            latch_byte = 1'b1;
          end
`ifdef UPD1771C_TIMEOUT_EN
          else if (step_cnt == CW'(TIMEOUT - 1)) begin
            state_d = ST_IDLE;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Strobe counter restarts on every state change; it times both BUSY and WAIT.
  always_ff @(posedge CLK) begin
    if (RES) begin
      step_cnt <= '0;
    end else if (phi2p) begin
      if (state_d != state_q) step_cnt <= '0;
      else                    step_cnt <= step_cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      cmd_q     <= 8'h00;
      idx_q     <= 2'd0;
      flag_en_q <= 1'b0;
      per_q     <= 8'h00;
      vol_q     <= 5'd0;
    end else if (latch_byte) begin
      if (state_q == ST_IDLE) begin
        cmd_q <= bus.PA_I;
        idx_q <= 2'd0;
      end else begin
        idx_q <= idx_q + 2'd1;
        case (idx_q)
          2'd0:    flag_en_q <= bus.PA_I[7];
          2'd1:    per_q     <= bus.PA_I;
          default: vol_q     <= bus.PA_I[4:0];
        endcase
      end
    end
  end

  // 9-bit P+1 keeps P=0xFF from wrapping to a zero-length half period.
  assign half_len = TW'({1'b0, period} + 9'd1) * TW'(DIV_STEP);

  always_ff @(posedge CLK) begin
    if (RES) begin
      enabled  <= 1'b0;
      level    <= 1'b0;
      period   <= 8'h00;
      volume   <= 5'd0;
      tone_cnt <= '0;
    end else if (exec_pkt) begin
      if (cmd_q == 8'h02 && flag_en_q) begin
        period   <= per_q;
        volume   <= vol_q;
        enabled  <= 1'b1;
        level    <= 1'b1;
        tone_cnt <= '0;
      end else if (cmd_q == 8'h02 || cmd_q == 8'h00) begin
        enabled <= 1'b0;
      end
    end else if (phi2p && enabled) begin
      if (tone_cnt == half_len - TW'(1)) begin
        tone_cnt <= '0;
        level    <= ~level;
      end else begin
        tone_cnt <= tone_cnt + TW'(1);
      end
    end
  end

  assign AOUT      = (enabled && level) ? {volume, 3'b000} : 8'h00;
  assign bus.PA_O  = 8'h00;
  assign bus.PA_OE = 8'h00;
  assign bus.PB_O  = {7'b0, state_q == ST_WAIT};
  assign bus.PB_OE = 8'h01;

  logic unused_pins;
`ifdef UPD1771C_TIMEOUT_EN
  assign unused_pins = &{1'b0, CH1, CH2, bus.PB_I[5:0]};
`else
  assign unused_pins = &{1'b0, CH1, CH2, bus.PB_I[5:0], 1'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_upd1771c_sound.sv
// Directed bench for upd1771c_sound: packet handshake timing, tone periods, silence,
// held/BUSY writes, reset mid-packet and (with UPD1771C_TIMEOUT_EN) packet timeout.
module tb_upd1771c_sound;
  logic       clk = 1'b0;
  logic       res, cken, ch1, ch2;
  logic [7:0] aout;

  upd1771c_sound_if bus();

  upd1771c_sound dut (
    .CLK (clk),
    .RES (res),
    .CKEN(cken),
    .CH1 (ch1),
    .CH2 (ch2),
    .bus (bus),
    .AOUT(aout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Four CLKs per strobe with CKEN held high.
  localparam int HALF_35 = 54 * 8 * 4;
  localparam int HALF_4F = 80 * 8 * 4;
  localparam int DSB_DLY = 8 * 4;

  int   cycle = 0, lastFall = 0, lastRise = 0, dsbRises = 0;
  logic dsbPrev = 1'b0;
  logic dsbLow;

  always @(negedge clk) begin
    cycle++;
    if (bus.PB_O[0] !== dsbPrev) begin
      if (bus.PB_O[0] === 1'b1) begin
        lastRise = cycle;
        dsbRises++;
      end else begin
        lastFall = cycle;
      end
      dsbPrev = bus.PB_O[0];
    end
  end

  function automatic void expectVal(string tag, logic [31:0] v);
    sb.push_back('{tag, v});
  endfunction

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed=0x%0h expected=none", observed);
      return;
    end
    e = sb.pop_front();
    assert (observed === e.exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", e.tag, observed, e.exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int lowCyc, input int highCyc);
    @(negedge clk);
    bus.PA_I = data;
    bus.PB_I = 8'h3F;
    repeat (lowCyc) @(negedge clk);
    dsbLow   = bus.PB_O[0];
    bus.PB_I = 8'hFF;
    repeat (highCyc) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] data);
    applyStimulus(data, 8, 72);
  endtask

  task automatic measureHalf(output int len, output logic [7:0] hi);
    logic [7:0] prev;
    int n;
    len = -1;
    hi  = 8'h00;
    @(negedge clk);
    prev = aout;
    n = 0;
    while (aout === prev && n < 6000) begin @(negedge clk); n++; end
    if (aout === prev) return;
    prev = aout;
    if (aout != 8'h00) hi = aout;
    n = 0;
    while (aout === prev && n < 6000) begin @(negedge clk); n++; end
    if (aout !== prev) begin
      len = n;
      if (aout != 8'h00) hi = aout;
    end
  endtask

  task automatic silentWindow(output logic [7:0] acc);
    acc = 8'h00;
    repeat (3000) begin @(negedge clk); acc |= aout; end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         len, r0;
    logic [7:0] hi, acc;

    res = 1'b1; cken = 1'b1; ch1 = 1'b1; ch2 = 1'b0;
    bus.PA_I = 8'h00; bus.PB_I = 8'hFF;
    repeat (12) @(negedge clk);
    expectVal("reset_pb_o", 32'h00);  checkOutput(32'(bus.PB_O));
    expectVal("reset_pb_oe", 32'h01); checkOutput(32'(bus.PB_OE));
    expectVal("reset_pa_oe", 32'h00); checkOutput(32'(bus.PA_OE));
    expectVal("reset_pa_o", 32'h00);  checkOutput(32'(bus.PA_O));
    expectVal("reset_aout", 32'h00);  checkOutput(32'(aout));
    res = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] packet 02,80,35,15");
    sendByte(8'h02);
    expectVal("p1_dsb_after_b1", 1); checkOutput(32'(bus.PB_O[0]));
    sendByte(8'h80);
    expectVal("p1_dsb_low_b2", 0);    checkOutput(32'(dsbLow));
    expectVal("p1_dsb_delay_b2", DSB_DLY); checkOutput(32'(lastRise - lastFall));
    expectVal("p1_dsb_after_b2", 1);  checkOutput(32'(bus.PB_O[0]));
    sendByte(8'h35);
    expectVal("p1_dsb_low_b3", 0);    checkOutput(32'(dsbLow));
    expectVal("p1_dsb_delay_b3", DSB_DLY); checkOutput(32'(lastRise - lastFall));
    expectVal("p1_dsb_after_b3", 1);  checkOutput(32'(bus.PB_O[0]));
    r0 = dsbRises;
    sendByte(8'h15);
    expectVal("p1_dsb_low_b4", 0);    checkOutput(32'(dsbLow));
    expectVal("p1_dsb_after_b4", 0);  checkOutput(32'(bus.PB_O[0]));
    expectVal("p1_no_dsb_rise", 0);   checkOutput(32'(dsbRises - r0));
    measureHalf(len, hi);
    expectVal("p1_half_period", HALF_35); checkOutput(32'(len));
    expectVal("p1_aout_high", 32'hA8);    checkOutput(32'(hi));

    $display("[TB] packet 02,80,4F,15");
    sendByte(8'h02);
    sendByte(8'h80);
    sendByte(8'h4F);
`ifndef UPD1771C_TIMEOUT_EN
    measureHalf(len, hi);
    expectVal("p2_old_tone_holds", HALF_35); checkOutput(32'(len));
`endif
    sendByte(8'h15);
    measureHalf(len, hi);
    expectVal("p2_half_period", HALF_4F); checkOutput(32'(len));
    expectVal("p2_aout_high", 32'hA8);    checkOutput(32'(hi));

    $display("[TB] packet 02,00,35,15 then 00");
    sendByte(8'h02); sendByte(8'h00); sendByte(8'h35); sendByte(8'h15);
    expectVal("p3_dsb_after_b4", 0); checkOutput(32'(bus.PB_O[0]));
    silentWindow(acc);
    expectVal("p3_silent", 0); checkOutput(32'(acc));
    r0 = dsbRises;
    sendByte(8'h00);
    expectVal("cmd00_no_dsb_rise", 0); checkOutput(32'(dsbRises - r0));

    sendByte(8'h02); sendByte(8'h80); sendByte(8'h35); sendByte(8'h15);
    measureHalf(len, hi);
    expectVal("p4_half_period", HALF_35); checkOutput(32'(len));
    r0 = dsbRises;
    sendByte(8'h55);
    expectVal("cmd55_no_dsb_rise", 0); checkOutput(32'(dsbRises - r0));
    measureHalf(len, hi);
    expectVal("cmd55_tone_unchanged", HALF_35); checkOutput(32'(len));
    sendByte(8'h00);
    silentWindow(acc);
    expectVal("cmd00_silences_tone", 0); checkOutput(32'(acc));

    $display("[TB] held write and write during BUSY");
    applyStimulus(8'h02, 40, 72);
    expectVal("held_dsb_after_b1", 1); checkOutput(32'(bus.PB_O[0]));
    sendByte(8'h80);
    expectVal("held_dsb_after_b2", 1); checkOutput(32'(bus.PB_O[0]));
    sendByte(8'h4F);
    expectVal("held_dsb_after_b3", 1); checkOutput(32'(bus.PB_O[0]));
    sendByte(8'h15);
    expectVal("held_dsb_after_b4", 0); checkOutput(32'(bus.PB_O[0]));
    measureHalf(len, hi);
    expectVal("held_half_period", HALF_4F); checkOutput(32'(len));

    applyStimulus(8'h02, 8, 8);
    applyStimulus(8'h4F, 8, 72);
    expectVal("busy_wr_dsb_b1", 1); checkOutput(32'(bus.PB_O[0]));
    sendByte(8'h80);
    sendByte(8'h35);
    expectVal("busy_wr_dsb_b3", 1); checkOutput(32'(bus.PB_O[0]));
    sendByte(8'h15);
    expectVal("busy_wr_dsb_b4", 0); checkOutput(32'(bus.PB_O[0]));
    measureHalf(len, hi);
    expectVal("busy_wr_half_period", HALF_35); checkOutput(32'(len));
    expectVal("busy_wr_aout_high", 32'hA8);    checkOutput(32'(hi));

`ifdef UPD1771C_TIMEOUT_EN
    $display("[TB] packet timeout");
    sendByte(8'h02); sendByte(8'h80);
    expectVal("to_dsb_waiting", 1); checkOutput(32'(bus.PB_O[0]));
    repeat (1100) @(negedge clk);
    expectVal("to_dsb_dropped", 0); checkOutput(32'(bus.PB_O[0]));
    measureHalf(len, hi);
    expectVal("to_voice_unchanged", HALF_35); checkOutput(32'(len));
    r0 = dsbRises;
    sendByte(8'h15);
    expectVal("to_next_is_cmd", 0); checkOutput(32'(dsbRises - r0));
`endif

    $display("[TB] reset mid-packet");
    sendByte(8'h02); sendByte(8'h80);
    res = 1'b1;
    repeat (12) @(negedge clk);
    expectVal("midrst_dsb", 0);  checkOutput(32'(bus.PB_O[0]));
    expectVal("midrst_aout", 0); checkOutput(32'(aout));
    res = 1'b0;
    r0 = dsbRises;
    sendByte(8'h35);
    expectVal("midrst_partial_dropped", 0); checkOutput(32'(dsbRises - r0));
    sendByte(8'h02); sendByte(8'h80); sendByte(8'h35); sendByte(8'h15);
    measureHalf(len, hi);
    expectVal("midrst_new_tone", HALF_35); checkOutput(32'(len));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/upd1771c_sound.md
Name: upd1771c_sound

Overview:
- Cycle-level functional model of the NEC uPD1771C sound processor host interface and its tone voice. No ROM-based CPU core.
- The host writes command packets byte-by-byte over port A, using nCS/nWR on port B. Each byte is acknowledged through the DSB handshake on PB_O[0].
- A decoded tone packet drives a square-wave generator; amplitude is set by the packet's volume byte.
- Sits between the console CPU bus and the audio mixer.

Parameters:
- DIV_STEP, 8, number of PHI2 strobes per tone-period unit (half-period = (P+1)*DIV_STEP strobes).
- PROC_DLY, 8, PHI2 strobes from byte latch until DSB re-asserts.
- TIMEOUT, 256, PHI2 strobes allowed between packet bytes before abort (only with the optional feature).

Ports:
- CLK  in  1  system clock (6 MHz nominal).
- RES  in  1  reset. Synchronous, active-high; sampled on CLK rising edge.
- CKEN  in  1  clock enable; all state advances only when CKEN=1.
- CH1  in  1  oscillator mode pin; ignored, tie 1.
- CH2  in  1  oscillator mode pin; ignored, tie 0.
- PA_I  in  8  host data bus.
- PA_O  out  8  constant 0.
- PA_OE  out  8  constant 0 (port A input only).
- PB_I  in  8  [7]=nCS, [6]=nWR (both active-low); [5:0] unused.
- PB_O  out  8  [0]=DSB; [7:1]=0.
- PB_OE  out  8  constant 8'h01.
- AOUT  out  8  unsigned audio sample.

Behaviour:
- Phase counter: 2-bit, advances on each CKEN cycle. phi2p is a one-CLK strobe when the counter is 1, giving one strobe per 4 enabled clocks.
- All protocol and tone logic advances only on phi2p.
- Write detect: on phi2p, a write is recognised when nCS=0 and nWR=0, and the previous phi2p sample was not a write. PA_I is latched on that strobe.
- Write holding: a write held across several strobes latches exactly one byte.
- DSB after a latch: DSB=0 on the next CLK.
- DSB re-assert: after PROC_DLY strobes, DSB=1 if the packet still expects bytes; otherwise DSB stays 0.
- The first byte of a packet is accepted without DSB.
- States:
  - IDLE (DSB=0).
  - BUSY (processing delay, DSB=0).
  - WAIT (DSB=1, expecting the next byte).
- Transitions:
  - IDLE -> BUSY on write; byte0 = command.
  - BUSY -> WAIT after PROC_DLY if the byte index is below the packet length minus 1.
  - BUSY -> IDLE when the packet is complete; the packet executes at this point.
  - WAIT -> BUSY on write.
- Packet lengths:
  - cmd 0x02: 4 bytes (cmd, flags, period P, volume V).
  - cmd 0x00: 1 byte, silence.
  - Any other cmd: 1 byte, ignored; voice unchanged.
- Execute 0x02:
  - flags[7]=1: load P and V[4:0], restart the tone phase high.
  - flags[7]=0: silence.
  - flags[6:0] are ignored.
- A write arriving during BUSY is ignored.
- Tone generator: half-period counter counts (P+1)*DIV_STEP phi2p strobes, then toggles the level.
  - P=0 gives the fastest tone.
  - P=0xFF wraps correctly (9-bit arithmetic).
- AOUT = {V,3'b000} when enabled and level high; otherwise 0.
- A new tone packet takes effect only at packet completion; the old tone continues until then.
- Reset:
  - Phase counter 0.
  - State IDLE, DSB=0, voice disabled, AOUT=0, P=0, V=0, write-edge history cleared.
  - Reset mid-packet discards the partial packet.

Optional Feature:
- UPD1771C_TIMEOUT_EN defined: in WAIT, if no write arrives within TIMEOUT strobes, the block returns to IDLE with DSB=0, discards the partial packet, and leaves the voice unchanged.
- Undefined: WAIT persists indefinitely.

Test Plan:
- Reset: hold RES 2 us -> PB_O=0, PB_OE=8'h01, PA_OE=0, AOUT=0, DSB=0.
- Packet 02,80,35,15 using phi2p-aligned writes (8 CLK low, 72 CLK high) -> DSB rises after bytes 1-3 and falls on each write, stays 0 after byte 4. AOUT toggles 0/0xA8 with a half-period of 54*8=432 phi2p strobes.
- Packet 02,80,4F,15 -> half-period 80*8=640 strobes; old tone holds until the 4th byte completes.
- Packet 02,00,35,15, then single byte 00 -> AOUT stays 0; the 00 command keeps DSB=0 and silences a running tone.
- nCS/nWR held low for 40 CLK -> exactly one byte latched; a write during BUSY is ignored.
- With UPD1771C_TIMEOUT_EN, send only 02,80 -> after 256 strobes DSB=0 and IDLE. Reset asserted mid-packet -> IDLE, AOUT=0.
